datapath_controller: RTL and testbench

Instruction sequencer for the microprocessor datapath: fetches 20-bit instructions from a synchronous instruction memory, decodes them, and drives the datapath control inputs (`Ctrl`, `Sel`, `Wen`, `WA`, `RAA`, `RAB`, `Op`), consuming the datapath `Flag` for conditional branches. It sits next to the datapath, and both are instantiated side by side in the processor top. Execution is multi-cycle, with one instruction every three cycles.

---
 rtl/datapath_ctrl_pkg.sv | 67 ++++++
 rtl/datapath_ctrl_decoder.sv | 58 +++++
 rtl/datapath_controller.sv | 115 +++++++++++
 tb/tb_datapath_controller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_ctrl_pkg.sv
// Shared types, field slicers and select encodings for the datapath instruction sequencer.
// Pure declarations: no latency, no flow control.
package datapath_ctrl_pkg;

    typedef enum logic [3:0] {
        OPC_NOP  = 4'h0,
        OPC_ALU  = 4'h1,
        OPC_LDI  = 4'h2,
        OPC_IN   = 4'h3,
        OPC_JMP  = 4'h5,
        OPC_BRF  = 4'h6,
        OPC_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_HALTED
    } state_e;

    localparam logic [3:0] SEL_ALU     = 4'd0;
    localparam logic [3:0] SEL_IMM     = 4'd1;
    localparam logic [3:0] SEL_IN_BASE = 4'd8;
    localparam logic [2:0] CMP_OP      = 3'd7;

    // Control bundle handed from the decoder to the top before EXECUTE gating.
    typedef struct packed {
        logic       wen;
        logic [3:0] wa;
        logic [3:0] raa;
        logic [3:0] rab;
        logic [2:0] op;
        logic [3:0] sel;
        logic [7:0] ctrl;
    } ctrl_t;

    function automatic logic [3:0] f_opc(input logic [19:0] ir);
        return ir[19:16];
    endfunction

    function automatic logic [3:0] f_wa(input logic [19:0] ir);
        return ir[15:12];
    endfunction

    function automatic logic [3:0] f_ra(input logic [19:0] ir);
        return ir[11:8];
    endfunction

    function automatic logic [3:0] f_rb(input logic [19:0] ir);
        return ir[7:4];
    endfunction

    function automatic logic [3:0] f_aux(input logic [19:0] ir);
        return ir[3:0];
    endfunction

    function automatic logic [7:0] f_imm8(input logic [19:0] ir);
        return {ir[11:8], ir[7:4]};
    endfunction

    function automatic logic [7:0] f_tgt(input logic [19:0] ir);
        return {ir[15:12], ir[3:0]};
    endfunction

endpackage

// File: rtl/datapath_ctrl_decoder.sv
// Combinational instruction decoder: IR to datapath controls plus class flags.
// Zero latency; no flow control, the sequencer gates the result to EXECUTE.
module datapath_ctrl_decoder
    import datapath_ctrl_pkg::*;
(
    input  logic [19:0] i_ir,
    output ctrl_t       o_ctrl,
    output logic        o_illegal_op,
    output logic        o_is_branch,
    output logic        o_is_jump,
    output logic        o_is_halt
);

    logic [3:0] w_aux;

    assign w_aux = f_aux(i_ir);

    always_comb begin
        o_ctrl       = '0;
        o_illegal_op = 1'b0;
        o_is_branch  = 1'b0;
        o_is_jump    = 1'b0;
        o_is_halt    = 1'b0;
        case (f_opc(i_ir))
            OPC_NOP: ;
            OPC_ALU: begin
                o_ctrl.wen = 1'b1;
                o_ctrl.wa  = f_wa(i_ir);
                o_ctrl.raa = f_ra(i_ir);
                o_ctrl.rab = f_rb(i_ir);
                o_ctrl.op  = w_aux[2:0];
                o_ctrl.sel = SEL_ALU;
            end
            OPC_LDI: begin
                o_ctrl.wen  = 1'b1;
                o_ctrl.wa   = f_wa(i_ir);
                o_ctrl.ctrl = f_imm8(i_ir);
                o_ctrl.sel  = SEL_IMM;
            end
            OPC_IN: begin
                o_ctrl.wen = 1'b1;
                o_ctrl.wa  = f_wa(i_ir);
                o_ctrl.sel = SEL_IN_BASE | {1'b0, w_aux[2:0]};
            end
            OPC_JMP: o_is_jump = 1'b1;
            OPC_BRF: begin
                // Compare operands are presented so Flag settles before the closing edge.
                o_is_branch = 1'b1;
                o_ctrl.raa  = f_ra(i_ir);
                o_ctrl.rab  = f_rb(i_ir);
                o_ctrl.op   = CMP_OP;
            end
            OPC_HALT: o_is_halt = 1'b1;
            default:  o_illegal_op = 1'b1;
        endcase
    end

endmodule

// File: rtl/datapath_controller.sv
// Multi-cycle sequencer: FETCH/DECODE/EXECUTE, one instruction per three cycles.
// start is ignored while busy; controls are combinational from state and IR.
module datapath_controller
    import datapath_ctrl_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            halted,
    output logic            illegal,
    output logic [PC_W-1:0] imem_addr,
    input  logic [19:0]     imem_data,
    input  logic            Flag,
    output logic [7:0]      Ctrl,
    output logic [3:0]      Sel,
    output logic            Wen,
    output logic [3:0]      WA,
    output logic [3:0]      RAA,
    output logic [3:0]      RAB,
    output logic [2:0]      Op
);

    state_e          r_state;
    logic [PC_W-1:0] r_pc;
    logic [19:0]     r_ir;
    logic            r_busy;
    logic            r_halted;
    logic            r_illegal;

    ctrl_t           w_dec;
    logic            w_illegal_op;
    logic            w_is_branch;
    logic            w_is_jump;
    logic            w_is_halt;
    logic            w_exec;
    logic [PC_W-1:0] w_tgt;
    logic [PC_W-1:0] w_pc_inc;

    datapath_ctrl_decoder u_decoder (
        .i_ir         (r_ir),
        .o_ctrl       (w_dec),
        .o_illegal_op (w_illegal_op),
        .o_is_branch  (w_is_branch),
        .o_is_jump    (w_is_jump),
        .o_is_halt    (w_is_halt)
    );

    assign w_exec   = (r_state == ST_EXECUTE);
    assign w_tgt    = PC_W'(f_tgt(r_ir));
    assign w_pc_inc = r_pc + PC_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        r_state   <= ST_FETCH;
                        r_pc      <= '0;
                        r_busy    <= 1'b1;
                        r_halted  <= 1'b0;
                        r_illegal <= 1'b0;
                    end
                end
                ST_FETCH: r_state <= ST_DECODE;
                ST_DECODE: begin
                    r_ir    <= imem_data;
                    r_state <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    if (w_illegal_op) begin
                        r_illegal <= 1'b1;
                    end
                    // A halted PC keeps pointing at the HALT word.
                    if (w_is_halt) begin
                        r_state  <= ST_HALTED;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= ST_FETCH;
                        if (w_is_jump || (w_is_branch && Flag)) begin
                            r_pc <= w_tgt;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign halted    = r_halted;
    assign illegal   = r_illegal;
    assign imem_addr = r_pc;

    assign Wen  = w_exec & w_dec.wen;
    assign WA   = w_exec ? w_dec.wa   : '0;
    assign RAA  = w_exec ? w_dec.raa  : '0;
    assign RAB  = w_exec ? w_dec.rab  : '0;
    assign Op   = w_exec ? w_dec.op   : '0;
    assign Sel  = w_exec ? w_dec.sel  : '0;
    assign Ctrl = w_exec ? w_dec.ctrl : '0;

endmodule

// File: tb/tb_datapath_controller.sv
// Bench for datapath_controller: single-instruction vector table with a scoreboard queue,
// plus hand-written sequences for HALT, illegal opcodes, async reset and start-while-busy.
module tb_datapath_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic [7:0]  imem_addr;
    logic [19:0] imem_data;
    logic        flag;
    logic [7:0]  Ctrl;
    logic [3:0]  Sel;
    logic        Wen;
    logic [3:0]  WA;
    logic [3:0]  RAA;
    logic [3:0]  RAB;
    logic [2:0]  Op;

    logic [19:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [19:0] word;
        logic        flag;
        logic [7:0]  pc0;
        logic        wen;
        logic [3:0]  wa;
        logic [3:0]  raa;
        logic [3:0]  rab;
        logic [2:0]  op;
        logic [3:0]  sel;
        logic [7:0]  ctrl;
        logic        ill;
        logic [7:0]  next;
    } vec_t;

    vec_t vecs [12];
    vec_t sb [$];

    datapath_controller #(.PC_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .halted    (halted),
        .illegal   (illegal),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .Flag      (flag),
        .Ctrl      (Ctrl),
        .Sel       (Sel),
        .Wen       (Wen),
        .WA        (WA),
        .RAA       (RAA),
        .RAB       (RAB),
        .Op        (Op)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        start = 1'b0;
        flag  = 1'b0;
        rst   = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 20'h0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        do_reset();
        mem[0]    = {4'h5, v.pc0[7:4], 8'h00, v.pc0[3:0]};
        mem[v.pc0] = v.word;
        flag      = v.flag;
        sb.push_back(v);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(5);
        e = sb.pop_front();
        chk("vec_wen",  32'(Wen),       32'(e.wen));
        chk("vec_wa",   32'(WA),        32'(e.wa));
        chk("vec_raa",  32'(RAA),       32'(e.raa));
        chk("vec_rab",  32'(RAB),       32'(e.rab));
        chk("vec_op",   32'(Op),        32'(e.op));
        chk("vec_sel",  32'(Sel),       32'(e.sel));
        chk("vec_ctrl", 32'(Ctrl),      32'(e.ctrl));
        chk("vec_pc",   32'(imem_addr), 32'(e.pc0));
        tick(1);
        chk("vec_next", 32'(imem_addr), 32'(e.next));
        chk("vec_wen_off", 32'(Wen),    32'd0);
        chk("vec_ill",  32'(illegal),   32'(e.ill));
    endtask

    initial begin
        // word, flag, pc0, wen, wa, raa, rab, op, sel, ctrl, ill, next
        vecs[0]  = '{20'h212A0, 1'b0, 8'h10, 1'b1, 4'h1, 4'h0, 4'h0, 3'h0, 4'h1, 8'h2A, 1'b0, 8'h11};
        vecs[1]  = '{20'h13124, 1'b0, 8'h20, 1'b1, 4'h3, 4'h1, 4'h2, 3'h4, 4'h0, 8'h00, 1'b0, 8'h21};
        vecs[2]  = '{20'h37005, 1'b0, 8'h30, 1'b1, 4'h7, 4'h0, 4'h0, 3'h0, 4'hD, 8'h00, 1'b0, 8'h31};
        vecs[3]  = '{20'h3200B, 1'b0, 8'h38, 1'b1, 4'h2, 4'h0, 4'h0, 3'h0, 4'hB, 8'h00, 1'b0, 8'h39};
        vecs[4]  = '{20'h64120, 1'b1, 8'h05, 1'b0, 4'h0, 4'h1, 4'h2, 3'h7, 4'h0, 8'h00, 1'b0, 8'h40};
        vecs[5]  = '{20'h64120, 1'b0, 8'h05, 1'b0, 4'h0, 4'h1, 4'h2, 3'h7, 4'h0, 8'h00, 1'b0, 8'h06};
        vecs[6]  = '{20'h5F00F, 1'b0, 8'h50, 1'b0, 4'h0, 4'h0, 4'h0, 3'h0, 4'h0, 8'h00, 1'b0, 8'hFF};
        vecs[7]  = '{20'h00000, 1'b0, 8'hFF, 1'b0, 4'h0, 4'h0, 4'h0, 3'h0, 4'h0, 8'h00, 1'b0, 8'h00};
        vecs[8]  = '{20'h9ABCD, 1'b0, 8'h60, 1'b0, 4'h0, 4'h0, 4'h0, 3'h0, 4'h0, 8'h00, 1'b1, 8'h61};
        vecs[9]  = '{20'h1ABCF, 1'b0, 8'h70, 1'b1, 4'hA, 4'hB, 4'hC, 3'h7, 4'h0, 8'h00, 1'b0, 8'h71};
        vecs[10] = '{20'h4FFFF, 1'b0, 8'h7A, 1'b0, 4'h0, 4'h0, 4'h0, 3'h0, 4'h0, 8'h00, 1'b1, 8'h7B};
        vecs[11] = '{20'h00000, 1'b1, 8'h80, 1'b0, 4'h0, 4'h0, 4'h0, 3'h0, 4'h0, 8'h00, 1'b0, 8'h81};

        imem_data = 20'h0;

        // Reset state
        do_reset();
        chk("rst_busy",    32'(busy),      32'd0);
        chk("rst_halted",  32'(halted),    32'd0);
        chk("rst_illegal", 32'(illegal),   32'd0);
        chk("rst_addr",    32'(imem_addr), 32'd0);
        chk("rst_wen",     32'(Wen),       32'd0);
        chk("rst_sel",     32'(Sel),       32'd0);
        chk("rst_ctrl",    32'(Ctrl),      32'd0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // LDI r1,0x2A then HALT
        do_reset();
        mem[0] = 20'h212A0;
        mem[1] = 20'hF0000;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("ldi_busy_fetch", 32'(busy),      32'd1);
        chk("ldi_addr0",      32'(imem_addr), 32'd0);
        chk("ldi_wen_fetch",  32'(Wen),       32'd0);
        tick(1);
        chk("ldi_wen_decode", 32'(Wen),       32'd0);
        chk("ldi_sel_decode", 32'(Sel),       32'd0);
        tick(1);
        chk("ldi_wen_exec",   32'(Wen),       32'd1);
        chk("ldi_wa_exec",    32'(WA),        32'd1);
        chk("ldi_sel_exec",   32'(Sel),       32'd1);
        chk("ldi_ctrl_exec",  32'(Ctrl),      32'h2A);
        tick(1);
        chk("ldi_addr1",      32'(imem_addr), 32'd1);
        chk("ldi_wen_after",  32'(Wen),       32'd0);
        tick(3);
        chk("ldi_halted",     32'(halted),    32'd1);
        chk("ldi_busy_end",   32'(busy),      32'd0);

        // Illegal opcode is sticky until a restart
        do_reset();
        mem[0] = 20'h9ABCD;
        mem[2] = 20'hF0000;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        chk("ill_wen_exec",   32'(Wen),       32'd0);
        tick(1);
        chk("ill_set",        32'(illegal),   32'd1);
        chk("ill_continue",   32'(imem_addr), 32'd1);
        tick(6);
        chk("ill_halted",     32'(halted),    32'd1);
        chk("ill_sticky",     32'(illegal),   32'd1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("ill_cleared",    32'(illegal),   32'd0);
        chk("ill_restart",    32'(busy),      32'd1);

        // Async reset during EXECUTE of LDI, then start held with reset
        do_reset();
        mem[0] = 20'h212A0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        chk("arst_wen_pre",   32'(Wen),       32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_wen",       32'(Wen),       32'd0);
        chk("arst_ctrl",      32'(Ctrl),      32'd0);
        chk("arst_busy",      32'(busy),      32'd0);
        chk("arst_addr",      32'(imem_addr), 32'd0);
        start = 1'b1;
        @(negedge clk);
        tick(1);
        chk("arst_start_ign", 32'(busy),      32'd0);
        start = 1'b0;
        rst = 1'b0;
        tick(1);
        chk("arst_idle",      32'(busy),      32'd0);

        // start while busy must not restart
        do_reset();
        mem[3] = 20'hF0000;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        chk("sb_addr1",       32'(imem_addr), 32'd1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        chk("sb_addr2",       32'(imem_addr), 32'd2);
        chk("sb_busy",        32'(busy),      32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
